// File: rtl/answer_gen_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg -- shared types and constants for the answer generator.
//   digit_t      : one BCD digit (4 bits)
//   BCD_MAX      : largest legal BCD digit value
//   gen_state_t  : answer_gen FSM states
//   LFSR_TAPS    : tap mask for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
//   lfsr_feedback: XOR of the tapped bits, shifted into bit 0
// ---------------------------------------------------------------------------
package game_pkg;

  typedef logic [3:0] digit_t;

  localparam digit_t BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    COMMIT = 2'd2
  } gen_state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_feedback(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/answer_gen_if.sv
// ---------------------------------------------------------------------------
// answer_gen_if -- link between the comparator and the answer generator.
//   round, Max_digit          : comparator -> generator (draw request)
//   answer0..answer2          : committed BCD digits (ones, tens, hundreds)
//   answer_valid              : committed answer matches current round/width
//   busy                      : a draw is in progress
// Modports:
//   master : comparator side (drives round/Max_digit)
//   slave  : answer_gen side (drives answers and status)
// ---------------------------------------------------------------------------
interface answer_gen_if;
  import game_pkg::*;

  logic [1:0] round;
  logic [1:0] Max_digit;
  digit_t     answer0;
  digit_t     answer1;
  digit_t     answer2;
  logic       answer_valid;
  logic       busy;

  modport master (
    output round, Max_digit,
    input  answer0, answer1, answer2, answer_valid, busy
  );

  modport slave (
    input  round, Max_digit,
    output answer0, answer1, answer2, answer_valid, busy
  );

endinterface

// File: rtl/answer_gen_lfsr16.sv
// ---------------------------------------------------------------------------
// lfsr16 -- free-running 16-bit Fibonacci LFSR, shifting left.
//   clk     : system clock
//   restart : asynchronous active-high reset, loads seed
//   seed    : reset value (must be nonzero, otherwise the LFSR locks up)
//   q       : current register value
// ---------------------------------------------------------------------------
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        restart,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_feedback(lfsr_q)};
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      lfsr_q <= seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/answer_gen.sv
// ---------------------------------------------------------------------------
// answer_gen -- draws the secret BCD answer for the guess comparator.
//   clk     : system clock
//   restart : asynchronous active-high reset
//   bus     : answer_gen_if.slave (round, Max_digit in; answers, status out)
// Parameters:
//   SEED      : LFSR reset value (nonzero)
//   MAX_TRIES : consecutive rejected nibbles per digit before fallback (1..15)
// A new answer is drawn after reset and whenever round or Max_digit changes.
// Digits are collected in a shadow register and copied to the outputs in a
// single COMMIT cycle, so the outputs never show a partially drawn answer.
// Optional build macro ANSWER_LEAD_NONZERO_EN: the most significant digit of
// a multi-digit answer may not be zero.
// ---------------------------------------------------------------------------
module answer_gen
  import game_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic         clk,
  input  logic         restart,
  answer_gen_if.slave  bus
);

  localparam logic [3:0] TRY_LAST = 4'(MAX_TRIES - 1);

  logic [15:0] lfsr;
  digit_t      cand;
  logic        unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clk     (clk),
    .restart (restart),
    .seed    (SEED),
    .q       (lfsr)
  );

  assign cand           = lfsr[3:0];
  assign unused_lfsr_hi = ^lfsr[15:4];

  gen_state_t   state_q, state_d;
  logic [1:0]   round_q, round_d;
  logic [1:0]   maxd_q, maxd_d;
  logic         start_pending_q, start_pending_d;
  logic [1:0]   idx_q, idx_d;
  logic [3:0]   tries_q, tries_d;
  digit_t [2:0] shadow_q, shadow_d;
  digit_t [2:0] answer_q, answer_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;

  logic         trigger;
  logic [1:0]   last_idx;
  logic         lead_digit;
  logic         reject;
  logic         accept;
  digit_t       fallback_val;
  digit_t       accept_val;
  digit_t [2:0] commit_val;

  assign trigger  = start_pending_q || (bus.round != round_q) || (bus.Max_digit != maxd_q);
  assign last_idx = maxd_q - 2'd1;

`ifdef ANSWER_LEAD_NONZERO_EN
  assign lead_digit = (maxd_q >= 2'd2) && (idx_q == last_idx);
`else
  assign lead_digit = 1'b0;
`endif

  // The leading digit's fallback maps 10..15 to 1..6; a rejected zero can
  // only reach the fallback on that digit, and it is forced to 1.
  assign reject       = (cand > BCD_MAX) || (lead_digit && (cand == 4'd0));
  assign fallback_val = lead_digit ? ((cand > BCD_MAX) ? cand - 4'd9 : 4'd1)
                                   : cand - 4'd10;
  assign accept       = !reject || (tries_q == TRY_LAST);
  assign accept_val   = reject ? fallback_val : cand;

  // Digits at or above the configured width commit as zero.
  for (genvar gi = 0; gi < 3; gi++) begin : g_commit
    assign commit_val[gi] = (2'(gi) < maxd_q) ? shadow_q[gi] : 4'd0;
  end

  always_comb begin
    state_d         = state_q;
    round_d         = round_q;
    maxd_d          = maxd_q;
    start_pending_d = start_pending_q;
    idx_d           = idx_q;
    tries_d         = tries_q;
    shadow_d        = shadow_q;
    answer_d        = answer_q;
    valid_d         = valid_q;
    busy_d          = busy_q;

    if (trigger) begin
      // A trigger overrides any draw or commit in flight; the previously
      // committed answer stays on the outputs but is flagged invalid.
      round_d         = bus.round;
      maxd_d          = bus.Max_digit;
      start_pending_d = 1'b0;
      valid_d         = 1'b0;
      idx_d           = 2'd0;
      tries_d         = 4'd0;
      if (bus.Max_digit == 2'd0) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        state_d = DRAW;
        busy_d  = 1'b1;
      end
    end else begin
      case (state_q)
        DRAW: begin
          if (accept) begin
            shadow_d[idx_q] = accept_val;
            tries_d         = 4'd0;
            if (idx_q == last_idx) begin
              state_d = COMMIT;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            tries_d = tries_q + 4'd1;
          end
        end
        COMMIT: begin
          answer_d = commit_val;
          valid_d  = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state_q         <= IDLE;
      round_q         <= 2'd0;
      maxd_q          <= 2'd0;
      start_pending_q <= 1'b1;
      idx_q           <= 2'd0;
      tries_q         <= 4'd0;
      shadow_q        <= '0;
      answer_q        <= '0;
      valid_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      round_q         <= round_d;
      maxd_q          <= maxd_d;
      start_pending_q <= start_pending_d;
      idx_q           <= idx_d;
      tries_q         <= tries_d;
      shadow_q        <= shadow_d;
      answer_q        <= answer_d;
      valid_q         <= valid_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.answer0      = answer_q[0];
  assign bus.answer1      = answer_q[1];
  assign bus.answer2      = answer_q[2];
  assign bus.answer_valid = valid_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_answer_gen.sv
// ---------------------------------------------------------------------------
// tb_answer_gen -- self-checking bench for answer_gen.
// A reference model replays the LFSR sequence from SEED and applies the
// digit acceptance rules to predict each answer and the edge it commits on.
// MAX_TRIES is reduced to 3 so the fallback path is hit regularly.
// ---------------------------------------------------------------------------
module tb_answer_gen;
  import game_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          MT   = 3;

  logic clk = 1'b0;
  logic restart;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt;
  int   exp_dig[3];
  int   prev_ans[3];
  int   exp_commit;
  int   cur_round;

  always #5 clk = ~clk;

  answer_gen_if bus ();

  answer_gen #(.SEED(SEED), .MAX_TRIES(MT)) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  // Number of clock edges seen since reset was released.
  always @(posedge clk or posedge restart) begin
    if (restart) edge_cnt <= 0;
    else         edge_cnt <= edge_cnt + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // LFSR contents after n edges from SEED.
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] s;
    s = SEED;
    repeat (n) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s;
  endfunction

  // Predict the digits of a draw triggered at edge t and the commit edge.
  // Edge e uses the candidate present before it, i.e. lfsr_at(e-1).
  task automatic model_draw(input int t, input int maxd);
    int e;
    int tries;
    int c;
    bit lead;
    bit bad;
    bit done;
    logic [15:0] s;
    e = t + 1;
    for (int d = 0; d < 3; d++) exp_dig[d] = 0;
    for (int d = 0; d < maxd; d++) begin
      tries = 0;
      done  = 0;
`ifdef ANSWER_LEAD_NONZERO_EN
      lead = (maxd >= 2) && (d == maxd - 1);
`else
      lead = 0;
`endif
      while (!done) begin
        s   = lfsr_at(e - 1);
        c   = int'(s[3:0]);
        bad = (c > 9) || (lead && c == 0);
        e++;
        if (!bad) begin
          exp_dig[d] = c;
          done = 1;
        end else if (tries == MT - 1) begin
          exp_dig[d] = lead ? ((c > 9) ? c - 9 : 1) : c - 10;
          done = 1;
        end else begin
          tries++;
        end
      end
    end
    exp_commit = e;
  endtask

  task automatic check_answers(input string tag, input int a0, input int a1, input int a2);
    check_eq({tag, "_a0"}, int'(bus.answer0), a0);
    check_eq({tag, "_a1"}, int'(bus.answer1), a1);
    check_eq({tag, "_a2"}, int'(bus.answer2), a2);
  endtask

  // Called at a falling edge: apply new inputs and follow the draw to commit.
  task automatic do_txn(input int r, input int m);
    int t;
    int n;
    bus.round     = 2'(r);
    bus.Max_digit = 2'(m);
    cur_round     = r;
    t = edge_cnt + 1;
    if (m != 0) model_draw(t, m);
    @(negedge clk);
    if (m == 0) begin
      @(negedge clk);
      check_eq("off_busy", int'(bus.busy), 0);
      check_eq("off_valid", int'(bus.answer_valid), 0);
      check_answers("off_hold", prev_ans[0], prev_ans[1], prev_ans[2]);
      $display("txn round=%0d maxd=0 disabled, held %0d%0d%0d", r,
               prev_ans[2], prev_ans[1], prev_ans[0]);
    end else begin
      check_eq("busy_rise", int'(bus.busy), 1);
      check_eq("valid_low", int'(bus.answer_valid), 0);
      n = 0;
      while (!bus.answer_valid && n < m * MT + 4) begin
        @(negedge clk);
        n++;
      end
      check_eq("valid_seen", int'(bus.answer_valid), 1);
      check_eq("commit_edge", edge_cnt, exp_commit);
      check_answers("answer", exp_dig[0], exp_dig[1], exp_dig[2]);
      check_eq("busy_fall", int'(bus.busy), 0);
      for (int d = 0; d < 3; d++) prev_ans[d] = exp_dig[d];
      $display("txn round=%0d maxd=%0d trig_edge=%0d commit_edge=%0d answer=%0d%0d%0d",
               r, m, t, exp_commit, exp_dig[2], exp_dig[1], exp_dig[0]);
    end
  endtask

  // Digits must never leave the BCD range.
  always @(negedge clk) begin
    if (restart === 1'b0) begin
      check_eq("digit_range",
               int'((bus.answer0 > 4'd9) || (bus.answer1 > 4'd9) || (bus.answer2 > 4'd9)), 0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    for (int d = 0; d < 3; d++) prev_ans[d] = 0;
    restart       = 1'b1;
    bus.round     = 2'd0;
    bus.Max_digit = 2'd0;
    #1;
    check_answers("reset", 0, 0, 0);
    check_eq("reset_valid", int'(bus.answer_valid), 0);
    check_eq("reset_busy", int'(bus.busy), 0);

    // First draw after reset: start_pending triggers on edge 1.
    @(negedge clk);
    restart = 1'b0;
    do_txn(1, 3);

    // Asynchronous reset in the middle of a draw.
    bus.round = 2'd2;
    repeat (3) @(negedge clk);
    check_eq("busy_mid", int'(bus.busy), 1);
    #2;
    restart = 1'b1;
    #1;
    check_answers("async_reset", 0, 0, 0);
    check_eq("async_valid", int'(bus.answer_valid), 0);
    check_eq("async_busy", int'(bus.busy), 0);
    for (int d = 0; d < 3; d++) prev_ans[d] = 0;
    @(negedge clk);
    restart = 1'b0;
    do_txn(1, 1);

    // Disabled width, then a width change alone triggers a draw.
    do_txn(2, 0);
    do_txn(2, 2);

    // Retrigger mid-draw: old answer held and flagged invalid, draw restarts.
    bus.round     = 2'd3;
    bus.Max_digit = 2'd3;
    repeat (4) @(negedge clk);
    check_eq("retrig_valid", int'(bus.answer_valid), 0);
    check_answers("retrig_hold", prev_ans[0], prev_ans[1], prev_ans[2]);
    do_txn(0, 3);

    // Randomized sequence; round always changes (including wraparound).
    for (int i = 0; i < 60; i++) begin
      int r;
      int m;
      r = (cur_round + 1 + int'($urandom_range(0, 2))) % 4;
      m = int'($urandom_range(0, 3));
      do_txn(r, m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
